cve2_obi_arbiter: RTL

- Shares one single-ported OBI memory port between the cve2 instruction-fetch and load/store interfaces, giving a von Neumann memory behind the core.
- Arbitrates address phases, holds the selection stable while a request waits for grant, and records the owner of each outstanding transaction so in-order responses return to the correct requester.
- Sits between the core wrapper's instr_*/data_* ports and the SoC memory or interconnect.

---
 rtl/cve2_obi_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cve2_obi_arbiter.sv
// Two-to-one OBI arbiter: shares one memory port between the instruction-fetch
// and load/store requesters. It tracks the owner of each outstanding
// transaction so that in-order responses return to the right requester.
module cve2_obi_arbiter #(
  parameter int unsigned MaxOutstanding = 2,    // 1..4
  parameter bit          DataPriority   = 1'b1  // 1: data fixed priority, 0: round-robin
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,

  output logic        unexp_rsp_o
);

  localparam logic       OwnerInstr = 1'b0;
  localparam logic       OwnerData  = 1'b1;
  localparam logic [2:0] MaxCnt     = 3'(MaxOutstanding);

  logic                      lock_q, lock_d;
  logic                      lock_owner_q, lock_owner_d;
  logic                      last_owner_q, last_owner_d;
  logic [2:0]                count_q, count_d;
  // Owner FIFO as a shift register; bit 0 is the oldest outstanding owner.
  logic [MaxOutstanding-1:0] fifo_q, fifo_d;
  logic                      unexp_q, unexp_d;

  logic       sel;
  logic       sel_req;
  logic       not_full;
  logic       push;
  logic       pop;
  logic [2:0] wr_idx;

  // Owner selection: a stalled address phase keeps its owner until granted.
  always_comb begin
    if (lock_q) begin
      sel = lock_owner_q;
    end else if (instr_req_i && data_req_i) begin
      sel = DataPriority ? OwnerData : ~last_owner_q;
    end else if (instr_req_i) begin
      sel = OwnerInstr;
    end else begin
      sel = OwnerData;
    end
  end

  // Address-phase mux and combinational grant/response routing.
  always_comb begin
    not_full  = (count_q < MaxCnt);
    sel_req   = (sel == OwnerData) ? data_req_i : instr_req_i;
    // No bypass when full: a pop in the same cycle does not free a slot early.
    mem_req_o = sel_req && not_full;
    push      = mem_req_o && mem_gnt_i;
    pop       = mem_rvalid_i && (count_q != 3'd0);

    if (sel == OwnerData) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_addr_o  = instr_addr_i;
      mem_wdata_o = 32'h0;
    end

    instr_gnt_o    = push && (sel == OwnerInstr);
    data_gnt_o     = push && (sel == OwnerData);
    instr_rvalid_o = pop && (fifo_q[0] == OwnerInstr);
    data_rvalid_o  = pop && (fifo_q[0] == OwnerData);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    instr_err_o    = mem_err_i;
    data_err_o     = mem_err_i;
    unexp_rsp_o    = unexp_q;
  end

  // Next-state for lock, round-robin history, owner FIFO and the sticky error.
  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    last_owner_d = last_owner_q;
    count_d      = count_q;
    fifo_d       = fifo_q;
    unexp_d      = unexp_q;
    wr_idx       = pop ? (count_q - 3'd1) : count_q;

    if (mem_req_o && !mem_gnt_i) begin
      lock_d       = 1'b1;
      lock_owner_d = sel;
    end else if (push) begin
      lock_d = 1'b0;
    end

    if (pop) begin
      fifo_d = fifo_q >> 1;
    end
    if (push) begin
      last_owner_d = sel;
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        if (wr_idx == 3'(i)) begin
          fifo_d[i] = sel;
        end
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    if (mem_rvalid_i && (count_q == 3'd0)) begin
      unexp_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OwnerInstr;
      last_owner_q <= OwnerInstr;
      count_q      <= 3'd0;
      fifo_q       <= '0;
      unexp_q      <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      last_owner_q <= last_owner_d;
      count_q      <= count_d;
      fifo_q       <= fifo_d;
      unexp_q      <= unexp_d;
    end
  end

endmodule
